seg_static_digit: RTL and testbench

Downstream consumer of the free-running one-cycle count-done flag produced by the timer counter stage. Each flag pulse advances a single hex/decimal digit, which is shown statically on every seven-segment position at once; all digits are enabled and all show the same glyph. The block provides run/pause control, up/down counting, synchronous clear and a wrap pulse for chaining, and it owns the registered segment/select outputs that go to the pins.

---
 rtl/seg_static_digit.sv | 109 ++++++++++
 tb/tb_seg_static_digit.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/seg_static_digit.sv
// Single counting digit shown statically on every seven-segment position.
// Advances on timer ticks, with run/pause, up/down, clear and a wrap pulse for chaining.
module seg_static_digit #(
    parameter int DIG_NUM        = 6,
    parameter int MAX_DIGIT      = 15,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic               pause_req,
    input  logic               dir,
    input  logic               clear,
    output logic [3:0]         digit,
    output logic               wrap_pulse,
    output logic [DIG_NUM-1:0] seg_sel,
    output logic [7:0]         seg_led
);

    localparam logic [3:0]         MAX      = 4'(MAX_DIGIT);
    // Internal values are active-low; these masks flip both buses for active-high boards.
    localparam logic [7:0]         LED_MASK = SEG_ACTIVE_LOW ? 8'h00 : 8'hFF;
    localparam logic [DIG_NUM-1:0] SEL_MASK = SEG_ACTIVE_LOW ? '0 : '1;

    typedef enum logic {
        RUN   = 1'b0,
        PAUSE = 1'b1
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [3:0] digit_next;
    logic       wrap_next;
    logic [6:0] glyph;

    always_comb begin
        state_next = state;
        if (pause_req) begin
            state_next = (state == RUN) ? PAUSE : RUN;
        end
    end

    // clear outranks tick; a paused digit ignores ticks entirely.
    always_comb begin
        digit_next = digit;
        wrap_next  = 1'b0;
        if (clear) begin
            digit_next = 4'd0;
        end else if (tick && (state == RUN)) begin
            if (!dir) begin
                if (digit == MAX) begin
                    digit_next = 4'd0;
                    wrap_next  = 1'b1;
                end else begin
                    digit_next = digit + 4'd1;
                end
            end else begin
                if (digit == 4'd0) begin
                    digit_next = MAX;
                    wrap_next  = 1'b1;
                end else begin
                    digit_next = digit - 4'd1;
                end
            end
        end
    end

    // Active-low {g,f,e,d,c,b,a} glyphs.
    always_comb begin
        glyph = 7'h7F;
        case (digit)
            4'h0: glyph = 7'h40;
            4'h1: glyph = 7'h79;
            4'h2: glyph = 7'h24;
            4'h3: glyph = 7'h30;
            4'h4: glyph = 7'h19;
            4'h5: glyph = 7'h12;
            4'h6: glyph = 7'h02;
            4'h7: glyph = 7'h78;
            4'h8: glyph = 7'h00;
            4'h9: glyph = 7'h10;
            4'hA: glyph = 7'h08;
            4'hB: glyph = 7'h03;
            4'hC: glyph = 7'h46;
            4'hD: glyph = 7'h21;
            4'hE: glyph = 7'h06;
            4'hF: glyph = 7'h0E;
            default: glyph = 7'h7F;
        endcase
    end

    // Glyph lags digit by one edge; dp follows the new state on the toggling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            digit      <= 4'd0;
            wrap_pulse <= 1'b0;
            seg_sel    <= '1 ^ SEL_MASK;
            seg_led    <= 8'hFF ^ LED_MASK;
        end else begin
            state      <= state_next;
            digit      <= digit_next;
            wrap_pulse <= wrap_next;
            seg_sel    <= SEL_MASK;
            seg_led    <= {(state_next == RUN), glyph} ^ LED_MASK;
        end
    end

endmodule

// File: tb/tb_seg_static_digit.sv
// Drives a hex/active-low and a decimal/active-high instance with shared stimulus,
// comparing both against a modular-arithmetic reference model every cycle.
module tb_seg_static_digit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       pause_req = 1'b0;
    logic       dir = 1'b0;
    logic       clear = 1'b0;

    logic [3:0] hex_digit, dec_digit;
    logic       hex_wrap, dec_wrap;
    logic [5:0] hex_sel, dec_sel;
    logic [7:0] hex_led, dec_led;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seg_static_digit #(.DIG_NUM(6), .MAX_DIGIT(15), .SEG_ACTIVE_LOW(1'b1)) dut_hex (
        .clk(clk), .rst(rst), .tick(tick), .pause_req(pause_req), .dir(dir), .clear(clear),
        .digit(hex_digit), .wrap_pulse(hex_wrap), .seg_sel(hex_sel), .seg_led(hex_led)
    );

    seg_static_digit #(.DIG_NUM(6), .MAX_DIGIT(9), .SEG_ACTIVE_LOW(1'b0)) dut_dec (
        .clk(clk), .rst(rst), .tick(tick), .pause_req(pause_req), .dir(dir), .clear(clear),
        .digit(dec_digit), .wrap_pulse(dec_wrap), .seg_sel(dec_sel), .seg_led(dec_led)
    );

    logic [7:0] glyph_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                   8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    int    m_max  [2] = '{15, 9};
    bit    m_low  [2] = '{1'b1, 1'b0};
    string m_name [2] = '{"hex", "dec"};
    int    m_digit[2];
    int    m_shown[2];
    bit    m_wrap [2];
    bit    m_paused[2];
    bit    m_live [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_update();
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_digit[k]  = 0;
                m_wrap[k]   = 1'b0;
                m_paused[k] = 1'b0;
                m_live[k]   = 1'b0;
            end else begin
                m_shown[k] = m_digit[k];
                m_wrap[k]  = 1'b0;
                if (clear) begin
                    m_digit[k] = 0;
                end else if (tick && !m_paused[k]) begin
                    if (!dir) begin
                        m_wrap[k]  = (m_digit[k] == m_max[k]);
                        m_digit[k] = (m_digit[k] + 1) % (m_max[k] + 1);
                    end else begin
                        m_wrap[k]  = (m_digit[k] == 0);
                        m_digit[k] = (m_digit[k] + m_max[k]) % (m_max[k] + 1);
                    end
                end
                if (pause_req) m_paused[k] = !m_paused[k];
                m_live[k] = 1'b1;
            end
        end
    endtask

    task automatic check_output();
        logic [7:0] exp_led;
        logic [5:0] exp_sel;
        logic [7:0] g;
        logic [3:0] a_digit;
        logic       a_wrap;
        logic [5:0] a_sel;
        logic [7:0] a_led;
        for (int k = 0; k < 2; k++) begin
            g = glyph_tab[m_shown[k]];
            exp_led = m_live[k] ? {~m_paused[k], g[6:0]} : 8'hFF;
            exp_sel = m_live[k] ? 6'h00 : 6'h3F;
            if (!m_low[k]) begin
                exp_led = ~exp_led;
                exp_sel = ~exp_sel;
            end
            a_digit = (k == 0) ? hex_digit : dec_digit;
            a_wrap  = (k == 0) ? hex_wrap  : dec_wrap;
            a_sel   = (k == 0) ? hex_sel   : dec_sel;
            a_led   = (k == 0) ? hex_led   : dec_led;
            check($sformatf("%s.digit", m_name[k]), 32'(a_digit), 32'(m_digit[k]));
            check($sformatf("%s.wrap", m_name[k]), 32'(a_wrap), 32'(m_wrap[k]));
            check($sformatf("%s.seg_sel", m_name[k]), 32'(a_sel), 32'(exp_sel));
            check($sformatf("%s.seg_led", m_name[k]), 32'(a_led), 32'(exp_led));
        end
    endtask

    task automatic apply_stimulus(input logic t, input logic p, input logic d,
                                  input logic c, input logic r);
        tick = t; pause_req = p; dir = d; clear = c; rst = r;
        @(posedge clk);
        model_update();
        #1;
        check_output();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_digit[k] = 0; m_shown[k] = 0; m_wrap[k] = 1'b0;
            m_paused[k] = 1'b0; m_live[k] = 1'b0;
        end

        // Reset and startup
        for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("rst.hex_led", 32'(hex_led), 32'h FF);
        check("rst.hex_sel", 32'(hex_sel), 32'h3F);
        check("rst.dec_led", 32'(dec_led), 32'h00);
        check("rst.dec_sel", 32'(dec_sel), 32'h00);
        idle(1);
        check("start.hex_sel", 32'(hex_sel), 32'h00);
        check("start.hex_led", 32'(hex_led), 32'hC0);
        check("start.hex_digit", 32'(hex_digit), 32'h0);
        check("start.dec_led", 32'(dec_led), 32'h3F);

        // Sixteen up ticks: hex runs 0..F and wraps back to 0
        for (int i = 0; i < 16; i++) begin
            apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            idle(4);
        end
        check("upwrap.hex_digit", 32'(hex_digit), 32'h0);
        check("upwrap.hex_led", 32'(hex_led), 32'hC0);

        // Down wrap from 0
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check("downwrap.dec_digit", 32'(dec_digit), 32'h9);
        check("downwrap.dec_wrap", 32'(dec_wrap), 32'h1);
        idle(1);
        check("downwrap.dec_led", 32'(dec_led), 32'h6F);
        check("downwrap.dec_wrap_low", 32'(dec_wrap), 32'h0);

        // Pause at digit 3, ignore ticks, resume and advance
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1);
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            idle(1);
        end
        check("pause.hex_led", 32'(hex_led), 32'h30);
        check("pause.hex_digit", 32'(hex_digit), 32'h3);
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1);
        check("resume.hex_digit", 32'(hex_digit), 32'h4);
        check("resume.hex_led", 32'(hex_led), 32'h99);

        // Simultaneous tick and pause_req, in RUN then in PAUSE
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("sim_run.hex_digit", 32'(hex_digit), 32'h3);
        check("sim_run.hex_dp", 32'(hex_led[7]), 32'h0);
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("sim_pause.hex_digit", 32'(hex_digit), 32'h3);
        check("sim_pause.hex_dp", 32'(hex_led[7]), 32'h1);

        // Clear beats a wrapping tick
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        check("clear.hex_digit", 32'(hex_digit), 32'h0);
        check("clear.hex_wrap", 32'(hex_wrap), 32'h0);

        // Reset on a wrapping tick
        apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        check("midrst.hex_digit", 32'(hex_digit), 32'h0);
        check("midrst.hex_wrap", 32'(hex_wrap), 32'h0);
        check("midrst.hex_led", 32'(hex_led), 32'hFF);
        idle(1);
        check("midrst.hex_dp_run", 32'(hex_led[7]), 32'h1);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            apply_stimulus(1'(($urandom % 3) == 0), 1'(($urandom % 8) == 0), 1'($urandom % 2),
                           1'(($urandom % 20) == 0), 1'(($urandom % 97) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
